// File: rtl/fb_reader_if.sv
// Memory read port plus (x, y, cidx) beat stream of the framebuffer raster reader.
interface fb_reader_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 2,
  parameter int ADDRW = 12
);
  logic                    mem_re;
  logic [ADDRW-1:0]        mem_addr;
  logic [CIDXW-1:0]        mem_data;
  logic                    valid;
  logic                    ready;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [CIDXW-1:0]        cidx;

  modport master (output mem_re, mem_addr, valid, x, y, cidx, input mem_data, ready);
  modport slave  (input mem_re, mem_addr, valid, x, y, cidx, output mem_data, ready);
endinterface

// File: rtl/fb_reader.sv
// Raster reader: scans WIDTH x HEIGHT cells through a 1-cycle sync read port into a 2-entry beat FIFO.
// Define FB_READER_SKIPZERO_EN to drop cells whose colour index is zero.
module fb_reader #(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48,
  parameter int CIDXW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  fb_reader_if.master bus
);
  localparam int ADDRW  = (WIDTH*HEIGHT > 1) ? $clog2(WIDTH*HEIGHT) : 1;
  localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [CIDXW-1:0] cidx;
  } beat_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t           state;
  logic [XW-1:0]    rx, tag_x;
  logic [YW-1:0]    ry, tag_y;
  logic [ADDRW-1:0] addr;
  // bit 0 is the read presented this cycle (mem_re), bit STAGES is its data landing
  logic [STAGES:0]  vld_pipe;

  beat_t      fifo [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt, cnt_nxt;
  logic       land, bypass, valid, pop, push, fifo_pop, credit_ok, last;
  beat_t      land_beat, head;

`ifdef FB_READER_SKIPZERO_EN
  assign land = vld_pipe[STAGES] && (bus.mem_data != '0);
`else
  assign land = vld_pipe[STAGES];
`endif

  assign land_beat = '{x: tag_x, y: tag_y, cidx: bus.mem_data};
  // Landing data is visible straight away when the FIFO is empty, so the first beat costs no extra cycle.
  assign bypass    = (cnt == 2'd0) && land;
  assign head      = bypass ? land_beat : fifo[rd_ptr];
  assign valid     = (cnt != 2'd0) || land;
  assign pop       = valid && bus.ready;
  assign push      = land && !(bypass && bus.ready);
  assign fifo_pop  = pop && (cnt != 2'd0);
  assign cnt_nxt   = cnt + 2'(push) - 2'(fifo_pop);
  // Buffered beats plus the read still in flight must leave room for the next read.
  assign credit_ok = (3'(cnt_nxt) + 3'(vld_pipe[0])) < 3'd2;
  assign last      = (rx == XW'(WIDTH-1)) && (ry == YW'(HEIGHT-1));

  assign bus.mem_re   = vld_pipe[0];
  assign bus.mem_addr = addr;
  assign bus.valid    = valid;
  assign bus.x        = CORDW'(head.x);
  assign bus.y        = CORDW'(head.y);
  assign bus.cidx     = head.cidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= land_beat;
        wr_ptr       <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rx       <= '0;
      ry       <= '0;
      addr     <= '0;
      tag_x    <= '0;
      tag_y    <= '0;
      vld_pipe <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      vld_pipe[0]        <= 1'b0;
      done               <= 1'b0;
      if (vld_pipe[0]) begin
        tag_x <= rx;
        tag_y <= ry;
      end
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            state       <= READ;
            busy        <= 1'b1;
            rx          <= '0;
            ry          <= '0;
            addr        <= '0;
            vld_pipe[0] <= 1'b1;
          end
        end
        READ: begin
          if (vld_pipe[0] && last) begin
            state <= DRAIN;
          end else begin
            vld_pipe[0] <= credit_ok;
            if (vld_pipe[0]) begin
              addr <= addr + 1'b1;
              if (rx == XW'(WIDTH-1)) begin
                rx <= '0;
                ry <= ry + 1'b1;
              end else begin
                rx <= rx + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // The last read lands in the first DRAIN cycle, so cnt_nxt covers it.
          if (cnt_nxt == 2'd0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
